// File: rtl/control_unit_pipe_if.sv
// ID-stage control bundle: IF/ID handshake in, ID/EX control word out.
interface control_unit_pipe_if #(
    parameter int EX_W = 4
) ();
    logic            in_valid;
    logic            S;
    logic            I;
    logic [1:0]      mode;
    logic [3:0]      op_code;
    logic [3:0]      cond;
    logic [3:0]      status;
    logic            stall_in;
    logic            flush;
    logic            id_ready;
    logic            ex_valid;
    logic [EX_W-1:0] EX_command;
    logic            mem_read;
    logic            mem_write;
    logic            WB_en;
    logic            Imm;
    logic            B;
    logic            update;
    logic            mul_busy;

    modport master (
        output in_valid, S, I, mode, op_code, cond, status, stall_in, flush,
        input  id_ready, ex_valid, EX_command, mem_read, mem_write,
        input  WB_en, Imm, B, update, mul_busy
    );

    modport slave (
        input  in_valid, S, I, mode, op_code, cond, status, stall_in, flush,
        output id_ready, ex_valid, EX_command, mem_read, mem_write,
        output WB_en, Imm, B, update, mul_busy
    );
endinterface

// File: rtl/control_unit_pipe.sv
// ID-stage control decoder with registered ID/EX word and multi-cycle multiply FSM.
// Optional ARM condition evaluation enabled by defining CU_COND_CHECK_EN.
module control_unit_pipe #(
    parameter int              EX_W       = 4,
    parameter int              MUL_CYCLES = 4,
    parameter logic [EX_W-1:0] MUL_CMD    = EX_W'(4'b1010)
) (
    input logic               clk,
    input logic               rst,
    control_unit_pipe_if.slave cu
);
    localparam logic [1:0] MODE_ARITH = 2'b00;
    localparam logic [1:0] MODE_MEM   = 2'b01;
    localparam logic [1:0] MODE_BR    = 2'b10;
    localparam logic [1:0] MODE_MUL   = 2'b11;

    localparam logic [3:0] OP_MOV = 4'b1101;
    localparam logic [3:0] OP_MVN = 4'b1111;
    localparam logic [3:0] OP_ADD = 4'b0100;
    localparam logic [3:0] OP_ADC = 4'b0101;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_SBC = 4'b0110;
    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_ORR = 4'b1100;
    localparam logic [3:0] OP_EOR = 4'b0001;
    localparam logic [3:0] OP_CMP = 4'b1010;
    localparam logic [3:0] OP_TST = 4'b1000;

    localparam logic [3:0] EX_MOV = 4'b0001;
    localparam logic [3:0] EX_MVN = 4'b1001;
    localparam logic [3:0] EX_ADD = 4'b0010;
    localparam logic [3:0] EX_ADC = 4'b0011;
    localparam logic [3:0] EX_SUB = 4'b0100;
    localparam logic [3:0] EX_SBC = 4'b0101;
    localparam logic [3:0] EX_AND = 4'b0110;
    localparam logic [3:0] EX_ORR = 4'b0111;
    localparam logic [3:0] EX_EOR = 4'b1000;
    localparam logic [3:0] EX_CMP = 4'b0100;
    localparam logic [3:0] EX_TST = 4'b0110;
    localparam logic [3:0] EX_LDR = 4'b0010;
    localparam logic [3:0] EX_STR = 4'b0010;

    localparam logic [0:0] IDLE     = 1'b0;
    localparam logic [0:0] MUL_BUSY = 1'b1;

    localparam logic [3:0] MUL_LOAD = 4'(MUL_CYCLES - 1);

    typedef struct packed {
        logic            v;
        logic [EX_W-1:0] cmd;
        logic            rd;
        logic            wr;
        logic            wb;
        logic            imm;
        logic            b;
        logic            upd;
    } ctl_t;

    logic [0:0] state;
    logic [3:0] cnt;
    logic       mul_s;
    ctl_t       ctl_q;
    ctl_t       dec_w;
    ctl_t       mul_w;
    logic [3:0] d_cmd;
    logic       accept;
    logic       cond_ok;

    assign cu.id_ready = (state == IDLE) & ~cu.stall_in;
    assign accept      = cu.in_valid & cu.id_ready;

`ifdef CU_COND_CHECK_EN
    logic n_f, z_f, c_f, v_f;
    assign {n_f, z_f, c_f, v_f} = cu.status;

    always_comb begin
        cond_ok = 1'b0;
        unique case (cu.cond)
            4'b0000: cond_ok = z_f;
            4'b0001: cond_ok = ~z_f;
            4'b0010: cond_ok = c_f;
            4'b0011: cond_ok = ~c_f;
            4'b0100: cond_ok = n_f;
            4'b0101: cond_ok = ~n_f;
            4'b0110: cond_ok = v_f;
            4'b0111: cond_ok = ~v_f;
            4'b1000: cond_ok = c_f & ~z_f;
            4'b1001: cond_ok = ~c_f | z_f;
            4'b1010: cond_ok = (n_f == v_f);
            4'b1011: cond_ok = (n_f != v_f);
            4'b1100: cond_ok = ~z_f & (n_f == v_f);
            4'b1101: cond_ok = z_f | (n_f != v_f);
            4'b1110: cond_ok = 1'b1;
            default: cond_ok = 1'b0;
        endcase
    end
`else
    logic cond_unused;
    assign cond_unused = ^{cu.cond, cu.status};
    assign cond_ok     = 1'b1;
`endif

    always_comb begin
        dec_w   = '0;
        d_cmd   = '0;
        dec_w.v = 1'b1;
        unique case (1'b1)
            (cu.mode == MODE_ARITH): begin
                dec_w.upd = cu.S;
                dec_w.imm = cu.I;
                dec_w.wb  = 1'b1;
                unique case (cu.op_code)
                    OP_MOV: d_cmd = EX_MOV;
                    OP_MVN: d_cmd = EX_MVN;
                    OP_ADD: d_cmd = EX_ADD;
                    OP_ADC: d_cmd = EX_ADC;
                    OP_SUB: d_cmd = EX_SUB;
                    OP_SBC: d_cmd = EX_SBC;
                    OP_AND: d_cmd = EX_AND;
                    OP_ORR: d_cmd = EX_ORR;
                    OP_EOR: d_cmd = EX_EOR;
                    OP_CMP: begin d_cmd = EX_CMP; dec_w.wb = 1'b0; end
                    OP_TST: begin d_cmd = EX_TST; dec_w.wb = 1'b0; end
                    default: begin
                        dec_w.upd = 1'b0;
                        dec_w.imm = 1'b0;
                        dec_w.wb  = 1'b0;
                    end
                endcase
            end
            (cu.mode == MODE_MEM): begin
                dec_w.imm = cu.I;
                dec_w.rd  = cu.S;
                dec_w.wb  = cu.S;
                dec_w.wr  = ~cu.S;
                d_cmd     = cu.S ? EX_LDR : EX_STR;
            end
            (cu.mode == MODE_BR): begin
                dec_w.imm = cu.I;
                dec_w.b   = 1'b1;
            end
            default: ;
        endcase
        dec_w.cmd = EX_W'(d_cmd);
    end

    always_comb begin
        mul_w     = '0;
        mul_w.v   = 1'b1;
        mul_w.cmd = MUL_CMD;
        mul_w.wb  = 1'b1;
        mul_w.upd = mul_s;
    end

    // flush outranks everything but reset, including the multiply completion edge
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= '0;
            mul_s <= 1'b0;
            ctl_q <= '0;
        end else if (cu.flush) begin
            state <= IDLE;
            cnt   <= '0;
            ctl_q <= '0;
        end else if (state == MUL_BUSY) begin
            if (cnt == '0) begin
                ctl_q <= mul_w;
                state <= IDLE;
            end else begin
                cnt   <= cnt - 4'd1;
                ctl_q <= '0;
            end
        end else if (accept && cond_ok) begin
            if (cu.mode == MODE_MUL) begin
                state <= MUL_BUSY;
                cnt   <= MUL_LOAD;
                mul_s <= cu.S;
                ctl_q <= '0;
            end else begin
                ctl_q <= dec_w;
            end
        end else begin
            ctl_q <= '0;
        end
    end

    assign cu.ex_valid   = ctl_q.v;
    assign cu.EX_command = ctl_q.cmd;
    assign cu.mem_read   = ctl_q.rd;
    assign cu.mem_write  = ctl_q.wr;
    assign cu.WB_en      = ctl_q.wb;
    assign cu.Imm        = ctl_q.imm;
    assign cu.B          = ctl_q.b;
    assign cu.update     = ctl_q.upd;
    assign cu.mul_busy   = (state == MUL_BUSY);
endmodule

// File: tb/tb_control_unit_pipe.sv
// Directed self-checking bench for control_unit_pipe (default parameters).
module tb_control_unit_pipe;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    control_unit_pipe_if #(.EX_W(4)) bus ();

    control_unit_pipe dut (
        .clk (clk),
        .rst (rst),
        .cu  (bus)
    );

    localparam logic [1:0] M_AR = 2'b00;
    localparam logic [1:0] M_MEM = 2'b01;
    localparam logic [1:0] M_BR = 2'b10;
    localparam logic [1:0] M_MUL = 2'b11;

    // {ex_valid, EX_command, rd, wr, wb, imm, b, upd, busy}
    function automatic logic [11:0] E(
        input logic v, input logic [3:0] c, input logic rd, input logic wr,
        input logic wb, input logic imm, input logic b, input logic upd,
        input logic busy);
        return {v, c, rd, wr, wb, imm, b, upd, busy};
    endfunction

    function automatic logic [11:0] obs();
        return {bus.ex_valid, bus.EX_command, bus.mem_read, bus.mem_write,
                bus.WB_en, bus.Imm, bus.B, bus.update, bus.mul_busy};
    endfunction

    task automatic chk(input string tag, input logic [11:0] o,
                       input logic [11:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic s, input logic i,
                         input logic [1:0] m, input logic [3:0] op);
        bus.in_valid = v;
        bus.S        = s;
        bus.I        = i;
        bus.mode     = m;
        bus.op_code  = op;
    endtask

    logic [11:0] BUB, BUSY, ADD1, ADD0, CMP1, LDR, STR, BRW, NOPW, MULW;

    initial begin
        BUB  = 12'h000;
        BUSY = 12'h001;
        ADD1 = E(1, 4'b0010, 0, 0, 1, 1, 0, 1, 0);
        ADD0 = E(1, 4'b0010, 0, 0, 1, 0, 0, 0, 0);
        CMP1 = E(1, 4'b0100, 0, 0, 0, 0, 0, 1, 0);
        LDR  = E(1, 4'b0010, 1, 0, 1, 1, 0, 0, 0);
        STR  = E(1, 4'b0010, 0, 1, 0, 1, 0, 0, 0);
        BRW  = E(1, 4'b0000, 0, 0, 0, 0, 1, 0, 0);
        NOPW = E(1, 4'b0000, 0, 0, 0, 0, 0, 0, 0);
        MULW = E(1, 4'b1010, 0, 0, 1, 0, 0, 1, 0);

        rst          = 1'b1;
        bus.flush    = 1'b0;
        bus.stall_in = 1'b0;
        bus.cond     = 4'b1110;
        bus.status   = 4'b0000;
        drive(1, 1, 1, M_AR, 4'b0100);
        tick();
        chk("reset_c0", obs(), BUB);
        tick();
        chk("reset_c1", obs(), BUB);
        rst = 1'b0;
        #1;
        chk("ready_after_reset", {11'd0, bus.id_ready}, 12'd1);

        tick();
        chk("add_s1_i1", obs(), ADD1);
        drive(1, 1, 0, M_AR, 4'b1010);
        tick();
        chk("cmp", obs(), CMP1);
        drive(1, 1, 1, M_MEM, 4'b0000);
        tick();
        chk("ldr", obs(), LDR);
        drive(1, 0, 1, M_MEM, 4'b0000);
        tick();
        chk("str", obs(), STR);
        drive(1, 0, 0, M_BR, 4'b0000);
        tick();
        chk("branch", obs(), BRW);
        drive(1, 1, 1, M_AR, 4'b0011);
        tick();
        chk("undef_nop", obs(), NOPW);
        bus.in_valid = 1'b0;
        tick();
        chk("idle_bubble", obs(), BUB);

        drive(1, 1, 1, M_MUL, 4'b0000);
        tick();
        chk("mul_t0", obs(), BUSY);
        drive(1, 0, 0, M_AR, 4'b0100);
        bus.stall_in = 1'b1;
        #1;
        chk("mul_ready_low", {11'd0, bus.id_ready}, 12'd0);
        tick();
        chk("mul_t1_stall_ignored", obs(), BUSY);
        bus.stall_in = 1'b0;
        tick();
        chk("mul_t2", obs(), BUSY);
        tick();
        chk("mul_t3", obs(), BUSY);
        tick();
        chk("mul_word", obs(), MULW);
        chk("mul_ready_back", {11'd0, bus.id_ready}, 12'd1);
        tick();
        chk("add_after_mul", obs(), ADD0);
        bus.in_valid = 1'b0;

        drive(1, 0, 0, M_MUL, 4'b0000);
        tick();
        chk("fmul_t0", obs(), BUSY);
        bus.in_valid = 1'b0;
        tick();
        chk("fmul_t1", obs(), BUSY);
        bus.flush = 1'b1;
        tick();
        chk("fmul_flush", obs(), BUB);
        bus.flush = 1'b0;
        #1;
        chk("fmul_ready", {11'd0, bus.id_ready}, 12'd1);
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("fmul_no_word", obs(), BUB);
        end

        drive(1, 1, 0, M_MUL, 4'b0000);
        tick();
        bus.in_valid = 1'b0;
        repeat (3) tick();
        chk("cmul_t3", obs(), BUSY);
        bus.flush = 1'b1;
        tick();
        chk("cmul_flush_complete", obs(), BUB);
        bus.flush = 1'b0;
        tick();
        chk("cmul_after", obs(), BUB);

        drive(1, 1, 1, M_AR, 4'b0100);
        bus.flush = 1'b1;
        tick();
        chk("flush_single", obs(), BUB);
        bus.flush    = 1'b0;
        bus.in_valid = 1'b0;

        drive(1, 0, 0, M_AR, 4'b0100);
        bus.stall_in = 1'b1;
        #1;
        chk("stall_ready_low", {11'd0, bus.id_ready}, 12'd0);
        tick();
        chk("stall_b0", obs(), BUB);
        tick();
        chk("stall_b1", obs(), BUB);
        bus.stall_in = 1'b0;
        tick();
        chk("stall_release", obs(), ADD0);
        bus.in_valid = 1'b0;

        drive(1, 1, 0, M_MUL, 4'b0000);
        tick();
        bus.in_valid = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rmul_reset", obs(), BUB);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            chk("rmul_no_word", obs(), BUB);
        end

        drive(1, 1, 1, M_AR, 4'b0100);
        bus.cond   = 4'b0000;
        bus.status = 4'b0000;
        tick();
`ifdef CU_COND_CHECK_EN
        chk("cond_eq_z0", obs(), BUB);
`else
        chk("cond_eq_z0", obs(), ADD1);
`endif
        bus.status = 4'b0100;
        tick();
        chk("cond_eq_z1", obs(), ADD1);
        bus.cond = 4'b1111;
        tick();
`ifdef CU_COND_CHECK_EN
        chk("cond_nv", obs(), BUB);
`else
        chk("cond_nv", obs(), ADD1);
`endif
        drive(1, 1, 0, M_MUL, 4'b0000);
        tick();
`ifdef CU_COND_CHECK_EN
        chk("cond_mul_fail", obs(), BUB);
`else
        chk("cond_mul_fail", obs(), BUSY);
`endif
        bus.in_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
